// File: rtl/cnn_window_gen.sv
// Streaming 3x3 valid-mode window generator: two line buffers plus a 3x3 shift array.
// Optional CNN_WIN_STRIDE2_EN: emit only windows whose top-left row and column are both even.
module cnn_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic [DATA_WIDTH-1:0]         pix_i,
  input  logic                          pix_valid_i,
  output logic                          pix_ready_o,
  output logic [9*DATA_WIDTH-1:0]       win_o,
  output logic                          win_valid_o,
  input  logic                          win_ready_i,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col_o,
  output logic                          frame_done_o
);

  localparam int DW = DATA_WIDTH;
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  logic [DW-1:0] lb0_q [IMG_WIDTH];
  logic [DW-1:0] lb1_q [IMG_WIDTH];
  logic [DW-1:0] sa_q  [3][3];

  logic [DW-1:0]   col_n [3];
  logic [9*DW-1:0] win_n;
  logic            accept;
  logic            emit;
  logic            last_col;
  logic            last_row;

  assign pix_ready_o = !clear_i
                     && (!win_valid_o || win_ready_i);
  assign accept   = pix_valid_i && pix_ready_o;
  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RW'(IMG_HEIGHT - 1));

`ifdef CNN_WIN_STRIDE2_EN
  assign emit = (row_q >= RW'(2)) && (col_q >= CW'(2))
              && !row_q[0] && !col_q[0];
`else
  assign emit = (row_q >= RW'(2)) && (col_q >= CW'(2));
`endif

  // incoming column, top to bottom: row r-2, row r-1, row r
  always_comb begin
    col_n[0] = lb1_q[col_q];
    col_n[1] = lb0_q[col_q];
    col_n[2] = pix_i;
  end

  always_comb begin
    win_n = '0;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        if (dx < 2)
          win_n[(3*dy+dx)*DW +: DW] = sa_q[dy][dx+1];
        else
          win_n[(3*dy+dx)*DW +: DW] = col_n[dy];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clear_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
    end else if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pix_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int dy = 0; dy < 3; dy++)
        for (int dx = 0; dx < 3; dx++)
          sa_q[dy][dx] <= '0;
    end else if (accept) begin
      for (int dy = 0; dy < 3; dy++) begin
        sa_q[dy][0] <= sa_q[dy][1];
        sa_q[dy][1] <= sa_q[dy][2];
        sa_q[dy][2] <= col_n[dy];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_o        <= '0;
      win_valid_o  <= 1'b0;
      win_row_o    <= '0;
      win_col_o    <= '0;
      frame_done_o <= 1'b0;
    end else if (clear_i) begin
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= accept && last_col && last_row;
      if (accept) begin
        win_valid_o <= emit;
        if (emit) begin
          win_o     <= win_n;
          win_row_o <= row_q - RW'(2);
          win_col_o <= col_q - CW'(2);
        end
      end else if (win_ready_i) begin
        win_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Randomized bench for cnn_window_gen: 4x4 and 28x28 instances checked
// against a frame-level window model built from the stored image.
module tb_cnn_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clr;
  logic       wrdy;
  logic       v;
  logic [7:0] pix;

  logic        pr4, wv4, fd4;
  logic [71:0] w4;
  logic [1:0]  r4, c4;
  logic        pr28, wv28, fd28;
  logic [71:0] w28;
  logic [4:0]  r28, c28;

  int which;
  int cur_W, cur_H;

  cnn_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr),
    .pix_i(pix), .pix_valid_i(v && which == 0), .pix_ready_o(pr4),
    .win_o(w4), .win_valid_o(wv4), .win_ready_i(wrdy),
    .win_row_o(r4), .win_col_o(c4), .frame_done_o(fd4));

  cnn_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(28), .IMG_HEIGHT(28)) dut28 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr),
    .pix_i(pix), .pix_valid_i(v && which == 1), .pix_ready_o(pr28),
    .win_o(w28), .win_valid_o(wv28), .win_ready_i(wrdy),
    .win_row_o(r28), .win_col_o(c28), .frame_done_o(fd28));

  logic        cur_pr, cur_wv, cur_fd;
  logic [71:0] cur_w;
  int          cur_r, cur_c;

  always_comb begin
    cur_pr = pr4; cur_wv = wv4; cur_fd = fd4;
    cur_w = w4; cur_r = int'(r4); cur_c = int'(c4);
    if (which == 1) begin
      cur_pr = pr28; cur_wv = wv28; cur_fd = fd28;
      cur_w = w28; cur_r = int'(r28); cur_c = int'(c28);
    end
  end

  typedef struct {
    logic [71:0] w;
    int          r;
    int          c;
  } win_t;

  win_t got_q[$];
  win_t exp_q[$];
  win_t mon_t;

  logic [7:0] img [28][28];
  int tests = 0, fails = 0;
  int fd_cnt, fd_last, bubbles, stall_chk, stall_bad;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cur_wv && wrdy) begin
        mon_t.w = cur_w; mon_t.r = cur_r; mon_t.c = cur_c;
        got_q.push_back(mon_t);
      end
      if (cur_fd) begin
        fd_cnt++;
        if (cur_wv && cur_r == cur_H-3 && cur_c == cur_W-3)
          fd_last++;
      end
    end
  end

  task automatic start(input int sel, input int wd, input int ht);
    which = sel; cur_W = wd; cur_H = ht;
    got_q.delete(); exp_q.delete();
    fd_cnt = 0; fd_last = 0; bubbles = 0;
    stall_chk = 0; stall_bad = 0;
  endtask

  task automatic gen_img(input int pm);
    for (int r = 0; r < cur_H; r++)
      for (int c = 0; c < cur_W; c++)
        case (pm)
          0: img[r][c] = 8'(4*r + c);
          1: img[r][c] = 8'($urandom);
          default: img[r][c] = 8'h80;
        endcase
  endtask

  // every valid 3x3 window of the stored image, raster order
  task automatic build_exp();
    win_t t;
    for (int r = 0; r + 2 < cur_H; r++)
      for (int c = 0; c + 2 < cur_W; c++) begin
        t.w = '0; t.r = r; t.c = c;
        for (int k = 0; k < 9; k++)
          t.w[k*8 +: 8] = img[r + k/3][c + k%3];
`ifdef CNN_WIN_STRIDE2_EN
        if ((r % 2) == 0 && (c % 2) == 0) exp_q.push_back(t);
`else
        exp_q.push_back(t);
`endif
      end
  endtask

  function automatic int first_bad();
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i].w !== exp_q[i].w || got_q[i].r != exp_q[i].r
          || got_q[i].c != exp_q[i].c)
        return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // mode 0: stream, always ready; 1: random valid/ready;
  // 2: stall first window 5 cycles; 3: stream, downstream never ready
  task automatic drive(input int mode, input int npix);
    int idx = 0, guard = 0, sl;
    logic [71:0] held = '0;
    sl = (mode == 2) ? 5 : 0;
    while (idx < npix && guard < 20000) begin
      @(posedge clk); #1; guard++;
      pix = img[idx / cur_W][idx % cur_W];
      case (mode)
        0: begin v = 1'b1; wrdy = 1'b1; end
        1: begin v = ($urandom % 4) != 0; wrdy = ($urandom % 3) != 0; end
        2: begin
          v = 1'b1; wrdy = 1'b1;
          if (cur_wv && sl > 0) begin
            if (sl == 5) held = cur_w;
            wrdy = 1'b0;
          end
        end
        default: begin v = 1'b1; wrdy = 1'b0; end
      endcase
      @(negedge clk);
      if (mode == 2 && !wrdy) begin
        stall_chk++; sl--;
        if (cur_pr !== 1'b0 || cur_w !== held) stall_bad++;
      end
      if (v && cur_pr) idx++;
      else if (mode == 0) bubbles++;
    end
    tests++;
    if (idx < npix) begin
      fails++;
      $display("FAIL drive_timeout accepted=%0d required=%0d", idx, npix);
    end
  endtask

  task automatic drain();
    @(posedge clk); #1; v = 1'b0; wrdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    start(0, 4, 4);
    tests++;
    if ({wv4, w4, r4, c4, fd4, wv28, w28, r28, c28, fd28} !== '0) begin
      fails++;
      $display("FAIL reset_outputs wv4=%b wv28=%b required all zero", wv4, wv28);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    tests++;
    if (pr4 !== 1'b1 || pr28 !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready pr4=%b pr28=%b required 1", pr4, pr28);
    end
  endtask

  task automatic test_ramp();
    int e[9];
    logic [71:0] x;
    int n;
    start(0, 4, 4); gen_img(0); build_exp();
    drive(0, 16); drain();
`ifdef CNN_WIN_STRIDE2_EN
    n = 1;
`else
    n = 4;
`endif
    tests++;
    if (got_q.size() != n) begin
      fails++;
      $display("FAIL ramp_count got=%0d required=%0d", got_q.size(), n);
    end
    tests++;
    if (first_bad() != -1) begin
      fails++;
      $display("FAIL ramp_windows first mismatch at %0d", first_bad());
    end
    e = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    x = '0;
    for (int k = 0; k < 9; k++) x[k*8 +: 8] = 8'(e[k]);
    tests++;
    if (got_q.size() < 1 || got_q[0].w !== x
        || got_q[0].r != 0 || got_q[0].c != 0) begin
      fails++;
      $display("FAIL ramp_first got=%h required=%h at (0,0)",
               (got_q.size() > 0) ? got_q[0].w : 72'h0, x);
    end
`ifndef CNN_WIN_STRIDE2_EN
    e = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    for (int k = 0; k < 9; k++) x[k*8 +: 8] = 8'(e[k]);
    tests++;
    if (got_q.size() != 4 || got_q[3].w !== x
        || got_q[3].r != 1 || got_q[3].c != 1) begin
      fails++;
      $display("FAIL ramp_last got=%h required=%h at (1,1)",
               (got_q.size() > 0) ? got_q[got_q.size()-1].w : 72'h0, x);
    end
    tests++;
    if (fd_last != 1) begin
      fails++;
      $display("FAIL ramp_done_with_last got=%0d required=1", fd_last);
    end
`endif
    tests++;
    if (fd_cnt != 1 || bubbles != 0) begin
      fails++;
      $display("FAIL ramp_done_bubbles fd=%0d bub=%0d required 1,0", fd_cnt, bubbles);
    end
  endtask

  task automatic test_stall();
    start(0, 4, 4); gen_img(0); build_exp();
    drive(2, 16); drain();
    tests++;
    if (stall_chk != 5 || stall_bad != 0) begin
      fails++;
      $display("FAIL stall_hold cycles=%0d bad=%0d required 5,0", stall_chk, stall_bad);
    end
    tests++;
    if (first_bad() != -1) begin
      fails++;
      $display("FAIL stall_windows mismatch at %0d got=%0d required=%0d",
               first_bad(), got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_signed();
    int bad = 0;
    start(0, 4, 4); gen_img(2); build_exp();
    drive(1, 16); drain();
    foreach (got_q[i])
      for (int k = 0; k < 9; k++)
        if (got_q[i].w[k*8 +: 8] !== 8'h80) bad++;
    tests++;
    if (bad != 0 || got_q.size() == 0) begin
      fails++;
      $display("FAIL signed_elems bad=%0d windows=%0d required 0 bad", bad, got_q.size());
    end
    tests++;
    if (first_bad() != -1) begin
      fails++;
      $display("FAIL signed_windows mismatch at %0d", first_bad());
    end
  endtask

  task automatic test_clear();
    start(0, 4, 4); gen_img(0);
    drive(0, 6);
    @(posedge clk); #1; v = 1'b0; clr = 1'b1;
    @(negedge clk);
    tests++;
    if (cur_pr !== 1'b0) begin
      fails++;
      $display("FAIL clear_ready got=%b required=0", cur_pr);
    end
    @(posedge clk); #1; clr = 1'b0;
    @(negedge clk);
    tests++;
    if (cur_wv !== 1'b0 || cur_fd !== 1'b0) begin
      fails++;
      $display("FAIL clear_valid wv=%b fd=%b required 0,0", cur_wv, cur_fd);
    end
    gen_img(1); build_exp();
    drive(1, 16); drain();
    tests++;
    if (first_bad() != -1 || fd_cnt != 1) begin
      fails++;
      $display("FAIL clear_frame mismatch=%0d got=%0d required=%0d fd=%0d",
               first_bad(), got_q.size(), exp_q.size(), fd_cnt);
    end
  endtask

  task automatic test_async_reset();
    start(0, 4, 4); gen_img(0);
    drive(3, 11);
    @(negedge clk);
    tests++;
    if (cur_wv !== 1'b1) begin
      fails++;
      $display("FAIL areset_pre wv=%b required=1", cur_wv);
    end
    #2; rst_n = 1'b0; #1;
    tests++;
    if ({wv4, w4, r4, c4, fd4} !== '0) begin
      fails++;
      $display("FAIL areset_outputs wv=%b w=%h required zero", wv4, w4);
    end
    @(negedge clk); rst_n = 1'b1; v = 1'b0; wrdy = 1'b1;
    start(0, 4, 4); gen_img(1); build_exp();
    drive(1, 16); drain();
    tests++;
    if (first_bad() != -1 || fd_cnt != 1) begin
      fails++;
      $display("FAIL areset_frame mismatch=%0d got=%0d required=%0d fd=%0d",
               first_bad(), got_q.size(), exp_q.size(), fd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n, odd = 0;
    start(1, 28, 28);
    gen_img(1); build_exp(); drive(0, 784);
    gen_img(1); build_exp(); drive(0, 784);
    drain();
`ifdef CNN_WIN_STRIDE2_EN
    n = 2 * 169;
`else
    n = 2 * 676;
`endif
    tests++;
    if (got_q.size() != n) begin
      fails++;
      $display("FAIL b2b_count got=%0d required=%0d", got_q.size(), n);
    end
    tests++;
    if (first_bad() != -1) begin
      fails++;
      $display("FAIL b2b_windows mismatch at %0d", first_bad());
    end
    tests++;
    if (fd_cnt != 2 || bubbles != 0) begin
      fails++;
      $display("FAIL b2b_done_bubbles fd=%0d bub=%0d required 2,0", fd_cnt, bubbles);
    end
`ifdef CNN_WIN_STRIDE2_EN
    foreach (got_q[i]) if (got_q[i].r % 2 || got_q[i].c % 2) odd++;
    tests++;
    if (odd != 0) begin
      fails++;
      $display("FAIL b2b_even_coords odd=%0d required=0", odd);
    end
`else
    tests++;
    if (fd_last != 2) begin
      fails++;
      $display("FAIL b2b_done_with_last got=%0d required=2", fd_last);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wrdy = 1'b1; v = 1'b0; pix = '0;
    which = 0; cur_W = 4; cur_H = 4;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_ramp();
    test_stall();
    test_signed();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
